// File: rtl/spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_responder
//  Description : SPI mode-0 responder on the raw_clk domain. Oversamples the
//                SPI pins and deserialises MOSI into bytes. Serialises a
//                host-supplied byte (or a fill byte) onto MISO. Uses a
//                one-byte strobe/full and ready/clear handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
    input  logic       raw_clk,
    input  logic       reset,
    input  logic       spi_cs,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_strobe,
    output logic       tx_full,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_ready_clear,
    output logic       overrun,
    output logic       underrun,
    input  logic       status_clear,
    output logic       selected
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers and edge detectors
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_prev;
    logic                   r_sclk_prev;
    logic                   r_selected;

    logic w_cs_s;
    logic w_sclk_s;
    logic w_mosi_s;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sclk_rise;
    logic w_sclk_fall;

    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall   = r_cs_prev & ~w_cs_s;
    assign w_cs_rise   = ~r_cs_prev & w_cs_s;
    assign w_sclk_rise = ~r_sclk_prev & w_sclk_s;
    assign w_sclk_fall = r_sclk_prev & ~w_sclk_s;

    // Synchronise pins; the CS chain resets low so that a CS already held
    // low when reset releases never looks like a fall (it must rise first).
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            r_cs_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_prev   <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_selected  <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_cs_prev   <= w_cs_s;
            r_sclk_prev <= w_sclk_s;
            r_selected  <= ~w_cs_s;
        end
    end

    // ------------------------------------------------------------------
    // Transfer state, shifters and handshake registers
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [2:0] r_bit_count;
    logic [6:0] r_rx_shift;     // partial RX byte, newest bit in [0]
    logic [6:0] r_tx_shift;     // remaining TX bits; current bit lives in r_miso
    logic       r_miso;
    logic       r_miso_oe;
    logic [7:0] r_tx_hold;
    logic       r_tx_full;
    logic [7:0] r_rx_data;
    logic       r_rx_ready;
    logic       r_overrun;
    logic       r_underrun;

    logic [7:0] w_load_byte;
    logic       w_load;
    logic [7:0] w_rx_byte;

    // A load happens on CS fall in IDLE or on a byte-boundary SCLK fall.
    assign w_load_byte = r_tx_full ? r_tx_hold : FILL_BYTE;
    assign w_load      = (r_state == ST_IDLE) ? w_cs_fall
                       : (!w_cs_rise && w_sclk_fall && (r_bit_count == 3'd0));
    assign w_rx_byte   = {r_rx_shift, w_mosi_s};

    // Responder FSM with its datapath; clears are written before sets so a
    // flag set in the same cycle as its clear takes priority.
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_bit_count <= 3'd0;
            r_rx_shift  <= 7'd0;
            r_tx_shift  <= 7'd0;
            r_miso      <= 1'b1;
            r_miso_oe   <= 1'b0;
            r_tx_hold   <= 8'd0;
            r_tx_full   <= 1'b0;
            r_rx_data   <= 8'd0;
            r_rx_ready  <= 1'b0;
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            if (rx_ready_clear) begin
                r_rx_ready <= 1'b0;
            end
            if (status_clear) begin
                r_overrun  <= 1'b0;
                r_underrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_miso_oe <= 1'b0;
                    r_miso    <= 1'b1;
                    if (w_cs_fall) begin
                        r_state     <= ST_SHIFT;
                        r_bit_count <= 3'd0;
                        r_miso_oe   <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (w_cs_rise) begin
                        // Abort: drop partial RX and TX bytes.
                        r_state     <= ST_IDLE;
                        r_miso_oe   <= 1'b0;
                        r_miso      <= 1'b1;
                        r_bit_count <= 3'd0;
                        r_rx_shift  <= 7'd0;
                    end else begin
                        if (w_sclk_rise) begin
                            r_rx_shift  <= w_rx_byte[6:0];
                            r_bit_count <= r_bit_count + 3'd1;
                            if (r_bit_count == 3'd7) begin
                                r_rx_data  <= w_rx_byte;
                                r_rx_ready <= 1'b1;
                                if (r_rx_ready && !rx_ready_clear) begin
                                    r_overrun <= 1'b1;
                                end
                            end
                        end
                        if (w_sclk_fall && (r_bit_count != 3'd0)) begin
                            r_miso     <= r_tx_shift[6];
                            r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Shifter load: consume the holding register or fall back to fill.
            if (w_load) begin
                r_miso     <= w_load_byte[7];
                r_tx_shift <= w_load_byte[6:0];
                if (r_tx_full) begin
                    r_tx_full <= 1'b0;
                end else begin
                    r_underrun <= 1'b1;
                end
            end

            // Host write only lands in an empty register (as seen this cycle).
            if (tx_strobe && !r_tx_full) begin
                r_tx_hold <= tx_data;
                r_tx_full <= 1'b1;
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_miso_oe;
    assign tx_full     = r_tx_full;
    assign rx_data     = r_rx_data;
    assign rx_ready    = r_rx_ready;
    assign overrun     = r_overrun;
    assign underrun    = r_underrun;
    assign selected    = r_selected;

endmodule
`default_nettype wire

// File: tb/tb_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_responder
//  Description : Self-checking bench for spi_responder. A mode-0 master model
//                drives the pins; expected MISO and RX bytes are queued by a
//                bench-side model and popped as bytes complete.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_responder;

    localparam int         HALF = 6;
    localparam logic [7:0] FILL = 8'hFF;

    logic       raw_clk        = 1'b0;
    logic       reset          = 1'b1;
    logic       spi_cs         = 1'b1;
    logic       spi_clk        = 1'b0;
    logic       spi_mosi       = 1'b0;
    logic [7:0] tx_data        = 8'd0;
    logic       tx_strobe      = 1'b0;
    logic       rx_ready_clear = 1'b0;
    logic       status_clear   = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       overrun;
    logic       underrun;
    logic       selected;

    spi_responder #(
        .SYNC_STAGES (2),
        .FILL_BYTE   (FILL)
    ) dut (
        .raw_clk        (raw_clk),
        .reset          (reset),
        .spi_cs         (spi_cs),
        .spi_clk        (spi_clk),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .spi_miso_oe    (spi_miso_oe),
        .tx_data        (tx_data),
        .tx_strobe      (tx_strobe),
        .tx_full        (tx_full),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .rx_ready_clear (rx_ready_clear),
        .overrun        (overrun),
        .underrun       (underrun),
        .status_clear   (status_clear),
        .selected       (selected)
    );

    always #5 raw_clk = ~raw_clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_miso_q[$];
    logic [7:0] exp_rx_q[$];
    logic       m_full     = 1'b0;
    logic [7:0] m_hold     = 8'd0;
    logic       m_rx_ready = 1'b0;
    logic [7:0] m_rx_data  = 8'd0;
    logic       m_overrun  = 1'b0;
    logic       m_underrun = 1'b0;

    task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check_value({tag, "_tx_full"},  8'(tx_full),  8'(m_full));
        check_value({tag, "_rx_ready"}, 8'(rx_ready), 8'(m_rx_ready));
        check_value({tag, "_overrun"},  8'(overrun),  8'(m_overrun));
        check_value({tag, "_underrun"}, 8'(underrun), 8'(m_underrun));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_miso"},     8'(spi_miso),    8'd1);
        check_value({tag, "_miso_oe"},  8'(spi_miso_oe), 8'd0);
        check_value({tag, "_rx_data"},  rx_data,         8'd0);
        check_value({tag, "_selected"}, 8'(selected),    8'd0);
        check_flags(tag);
    endtask

    // Bench model of a shifter load (CS fall or byte-boundary fall).
    task automatic model_load();
        if (m_full) begin
            exp_miso_q.push_back(m_hold);
            m_full = 1'b0;
        end else begin
            exp_miso_q.push_back(FILL);
            m_underrun = 1'b1;
        end
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge raw_clk);
        tx_data   = d;
        tx_strobe = 1'b1;
        @(negedge raw_clk);
        tx_strobe = 1'b0;
        if (!m_full) begin
            m_hold = d;
            m_full = 1'b1;
        end
    endtask

    task automatic rx_clear();
        @(negedge raw_clk);
        rx_ready_clear = 1'b1;
        @(negedge raw_clk);
        rx_ready_clear = 1'b0;
        m_rx_ready = 1'b0;
    endtask

    task automatic flags_clear();
        @(negedge raw_clk);
        status_clear = 1'b1;
        @(negedge raw_clk);
        status_clear = 1'b0;
        m_overrun  = 1'b0;
        m_underrun = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge raw_clk);
        spi_cs = 1'b0;
        model_load();
        repeat (4) @(negedge raw_clk);
        check_value("sel_miso_oe", 8'(spi_miso_oe), 8'd1);
        check_value("sel_selected", 8'(selected), 8'd1);
    endtask

    task automatic cs_high();
        repeat (2) @(negedge raw_clk);
        spi_cs = 1'b1;
        exp_miso_q.delete();
        repeat (6) @(negedge raw_clk);
        check_value("desel_miso_oe", 8'(spi_miso_oe), 8'd0);
        check_value("desel_miso", 8'(spi_miso), 8'd1);
    endtask

    // Master model: nbits of a mode-0 transfer, MSB first.
    task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit scored);
        logic [7:0] got;
        logic [7:0] exp;
        logic [7:0] mask;
        logic       rdy_before;
        int         lat;
        got        = 8'd0;
        lat        = 0;
        rdy_before = m_rx_ready;
        if (scored && nbits == 8) exp_rx_q.push_back(mo);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[7-i];
            repeat (HALF) @(negedge raw_clk);
            got[7-i] = spi_miso;
            spi_clk  = 1'b1;
            for (int c = 1; c <= HALF; c++) begin
                @(negedge raw_clk);
                if (i == nbits - 1 && lat == 0 && rx_ready) lat = c;
            end
            spi_clk = 1'b0;
        end
        if (scored) begin
            if (exp_miso_q.size() == 0) begin
                check_value("miso_queue_empty", 8'd1, 8'd0);
            end else begin
                exp  = exp_miso_q.pop_front();
                mask = 8'(8'hFF << (8 - nbits));
                check_value("miso_byte", got & mask, exp & mask);
            end
            if (nbits == 8) begin
                repeat (4) @(negedge raw_clk);
                model_load();
                if (!rdy_before) check_value("rx_latency_le4", 8'(lat >= 1 && lat <= 4), 8'd1);
                if (rdy_before) m_overrun = 1'b1;
                m_rx_ready = 1'b1;
                exp        = exp_rx_q.pop_front();
                m_rx_data  = exp;
                check_value("rx_data", rx_data, exp);
                check_flags("byte");
            end
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge raw_clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Idle: SCLK toggles with CS high must do nothing.
        for (int k = 0; k < 4; k++) begin
            repeat (HALF) @(negedge raw_clk);
            spi_clk = ~spi_clk;
        end
        repeat (4) @(negedge raw_clk);
        check_reset_outputs("idle");

        // Single byte.
        tx_write(8'hA5);
        check_value("preload_tx_full", 8'(tx_full), 8'd1);
        cs_low();
        spi_byte(8'h3C, 8, 1'b1);
        cs_high();

        // Back-to-back with a strobe after the first load.
        rx_clear();
        flags_clear();
        tx_write(8'h11);
        cs_low();
        tx_write(8'h22);
        spi_byte(8'hF0, 8, 1'b1);
        rx_clear();
        spi_byte(8'h0F, 8, 1'b1);
        cs_high();

        // Underrun and overrun.
        rx_clear();
        flags_clear();
        cs_low();
        spi_byte(8'hC3, 8, 1'b1);
        spi_byte(8'h96, 8, 1'b1);
        cs_high();
        check_value("ovr_rx_data", rx_data, 8'h96);
        flags_clear();
        check_flags("status_clear");

        // Abort after 5 bits, then a full byte.
        rx_clear();
        cs_low();
        spi_byte(8'hE7, 5, 1'b1);
        cs_high();
        check_value("abort_rx_ready", 8'(rx_ready), 8'(m_rx_ready));
        check_value("abort_rx_data", rx_data, m_rx_data);
        cs_low();
        spi_byte(8'h81, 8, 1'b1);
        cs_high();

        // Asynchronous reset mid-byte.
        tx_write(8'h5A);
        cs_low();
        spi_byte(8'hAA, 3, 1'b0);
        @(posedge raw_clk);
        #2 reset = 1'b0;
        #1;
        m_full = 1'b0; m_rx_ready = 1'b0; m_rx_data = 8'd0;
        m_overrun = 1'b0; m_underrun = 1'b0;
        exp_miso_q.delete();
        exp_rx_q.delete();
        check_reset_outputs("async_reset");
        repeat (2) @(negedge raw_clk);
        reset = 1'b1;
        spi_byte(8'h77, 8, 1'b0);
        repeat (4) @(negedge raw_clk);
        check_value("stale_cs_rx_ready", 8'(rx_ready), 8'd0);
        check_value("stale_cs_miso_oe", 8'(spi_miso_oe), 8'd0);
        spi_cs = 1'b1;
        repeat (8) @(negedge raw_clk);
        cs_low();
        spi_byte(8'h5A, 8, 1'b1);
        cs_high();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
